// File: rtl/multdiv_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states, ALU opcodes,
// exception codes and the default exception destination register.
package multdiv_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    localparam logic [4:0]  ALU_OP_MUL      = 5'b00110;
    localparam logic [4:0]  ALU_OP_DIV      = 5'b00111;
    localparam logic [31:0] EXC_CODE_MULT   = 32'd4;
    localparam logic [31:0] EXC_CODE_DIV    = 32'd5;
    localparam logic [4:0]  RSTATUS_REG_DEF = 5'd30;

endpackage

// File: rtl/multdiv_sequencer_timeout.sv
// Saturating cycle counter bounding multiply/divide latency; tc flags the
// last permitted BUSY cycle.
module md_timeout_counter #(
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned MAX_CYCLES = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/multdiv_sequencer.sv
// Holds the pipeline front while the multi-cycle mult/div unit runs, then hands
// the result (or the $r30 exception write) to XM for exactly one cycle.
//
// state | meaning
// IDLE  | no op in flight; stall follows the DX mul/div decode
// BUSY  | unit running; pipeline frozen, counter bounding latency
// DONE  | result presented to XM for one cycle
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int unsigned MAX_CYCLES  = 40,
    parameter int unsigned CNT_W       = 6,
    parameter logic [4:0]  RSTATUS_REG = RSTATUS_REG_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dx_is_mul,
    input  logic        dx_is_div,
    input  logic [4:0]  dx_rd,
    input  logic        flush,
    input  logic        md_result_rdy,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        md_stall,
    output logic        out_valid,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data
);

    md_state_e   state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic        is_div_q, is_div_d;
    logic        ctrl_mult_q, ctrl_mult_d;
    logic        ctrl_div_q, ctrl_div_d;
    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic [31:0] out_data_q, out_data_d;
    logic        cnt_clr, cnt_en, cnt_tc;

    md_timeout_counter #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        is_div_d    = is_div_q;
        ctrl_mult_d = 1'b0;
        ctrl_div_d  = 1'b0;
        out_valid_d = 1'b0;
        out_rd_d    = 5'd0;
        out_data_d  = 32'd0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        md_stall    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                md_stall = dx_is_mul | dx_is_div;
                if ((dx_is_mul | dx_is_div) && !flush) begin
                    state_d     = ST_BUSY;
                    rd_d        = dx_rd;
                    is_div_d    = !dx_is_mul;
                    ctrl_mult_d = dx_is_mul;
                    ctrl_div_d  = !dx_is_mul;
                    cnt_clr     = 1'b1;
                end
            end
            ST_BUSY: begin
                md_stall = 1'b1;
                cnt_en   = 1'b1;
                // A squash wins over a same-cycle result or timeout.
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (md_result_rdy && !md_exception) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    out_rd_d    = rd_q;
                    out_data_d  = md_result;
                end else if (md_result_rdy || cnt_tc) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    out_rd_d    = RSTATUS_REG;
                    out_data_d  = is_div_q ? EXC_CODE_DIV : EXC_CODE_MULT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rd_q        <= 5'd0;
            is_div_q    <= 1'b0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_rd_q    <= 5'd0;
            out_data_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            is_div_q    <= is_div_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
            out_valid_q <= out_valid_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
        end
    end

    assign ctrl_mult = ctrl_mult_q;
    assign ctrl_div  = ctrl_div_q;
    assign out_valid = out_valid_q;
    assign out_rd    = out_rd_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer: each op's expected XM write is queued
// when it is issued and compared when out_valid appears.
module tb_multdiv_sequencer;

    localparam int          MAX_CYCLES = 40;
    localparam logic [4:0]  RSTATUS    = 5'd30;

    logic        clock = 1'b0;
    logic        reset;
    logic        dx_is_mul, dx_is_div, flush;
    logic [4:0]  dx_rd;
    logic        md_result_rdy, md_exception;
    logic [31:0] md_result;
    logic        ctrl_mult, ctrl_div, md_stall, out_valid;
    logic [4:0]  out_rd;
    logic [31:0] out_data;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid = 0;
    int n_expected = 0;
    logic [36:0] sb_q[$];

    multdiv_sequencer #(
        .MAX_CYCLES  (MAX_CYCLES),
        .CNT_W       (6),
        .RSTATUS_REG (RSTATUS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .dx_is_mul     (dx_is_mul),
        .dx_is_div     (dx_is_div),
        .dx_rd         (dx_rd),
        .flush         (flush),
        .md_result_rdy (md_result_rdy),
        .md_exception  (md_exception),
        .md_result     (md_result),
        .ctrl_mult     (ctrl_mult),
        .ctrl_div      (ctrl_div),
        .md_stall      (md_stall),
        .out_valid     (out_valid),
        .out_rd        (out_rd),
        .out_data      (out_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on every out_valid cycle.
    initial begin
        logic [36:0] exp;
        forever begin
            @(posedge clock);
            #4;
            if (out_valid === 1'b1) begin
                n_valid++;
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    exp = sb_q.pop_front();
                    chk("sb_rd", {27'd0, out_rd}, {27'd0, exp[36:32]});
                    chk("sb_data", out_data, exp[31:0]);
                end
            end else begin
                chk("idle_rd_zero", {27'd0, out_rd}, 32'd0);
                chk("idle_data_zero", out_data, 32'd0);
            end
        end
    end

    // One op from DX detection to return to IDLE; ready_c/flush_c of 0 mean never.
    task automatic run_op(input bit do_mul, input bit do_div, input logic [4:0] rd,
                          input int ready_c, input bit exc, input logic [31:0] res,
                          input int flush_c);
        int end_c;
        bit flushed;
        bit is_mul;
        is_mul  = do_mul;
        end_c   = 0;
        flushed = 1'b0;
        for (int c = 1; c <= MAX_CYCLES; c++) begin
            if (flush_c == c) begin
                flushed = 1'b1;
                end_c   = c;
                break;
            end
            if (ready_c == c || c == MAX_CYCLES) begin
                end_c = c;
                break;
            end
        end
        if (!flushed) begin
            if (ready_c == end_c && !exc)
                sb_q.push_back({rd, res});
            else
                sb_q.push_back({RSTATUS, is_mul ? 32'd4 : 32'd5});
            n_expected++;
        end

        dx_is_mul = do_mul;
        dx_is_div = do_div;
        dx_rd     = rd;
        #1;
        chk("c0_stall", {31'd0, md_stall}, 32'd1);
        chk("c0_ctrl", {30'd0, ctrl_mult, ctrl_div}, 32'd0);
        for (int c = 1; c <= end_c; c++) begin
            @(posedge clock);
            #1;
            chk("busy_stall", {31'd0, md_stall}, 32'd1);
            chk("ctrl_mult", {31'd0, ctrl_mult}, {31'd0, is_mul && c == 1});
            chk("ctrl_div", {31'd0, ctrl_div}, {31'd0, !is_mul && c == 1});
            chk("busy_no_valid", {31'd0, out_valid}, 32'd0);
            md_result_rdy = (c == ready_c);
            md_exception  = exc && (c == ready_c);
            md_result     = (c == ready_c) ? res : $urandom;
            flush         = (c == flush_c);
        end
        @(posedge clock);
        #1;
        md_result_rdy = 1'b0;
        md_exception  = 1'b0;
        flush         = 1'b0;
        if (flushed) begin
            dx_is_mul = 1'b0;
            dx_is_div = 1'b0;
            #1;
            chk("flush_idle_stall", {31'd0, md_stall}, 32'd0);
            chk("flush_no_valid", {31'd0, out_valid}, 32'd0);
            for (int c = end_c + 2; c <= ready_c + 2; c++) begin
                @(posedge clock);
                #1;
                md_result_rdy = (c == ready_c);
                md_result     = 32'hBAD0_0000;
                chk("flush_late_no_valid", {31'd0, out_valid}, 32'd0);
                chk("flush_late_stall", {31'd0, md_stall}, 32'd0);
            end
            md_result_rdy = 1'b0;
        end else begin
            #1;
            chk("done_stall", {31'd0, md_stall}, 32'd0);
            chk("done_valid", {31'd0, out_valid}, 32'd1);
            chk("done_ctrl", {30'd0, ctrl_mult, ctrl_div}, 32'd0);
            @(posedge clock);
            #1;
            dx_is_mul = 1'b0;
            dx_is_div = 1'b0;
            #1;
            chk("after_done_valid", {31'd0, out_valid}, 32'd0);
            chk("after_done_stall", {31'd0, md_stall}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        dx_is_mul     = 1'b0;
        dx_is_div     = 1'b0;
        dx_rd         = 5'd0;
        flush         = 1'b0;
        md_result_rdy = 1'b0;
        md_exception  = 1'b0;
        md_result     = 32'd0;
        #1;
        chk("rst_outputs", {ctrl_mult, ctrl_div, out_valid, out_rd, out_data[24:0]}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_stall", {31'd0, md_stall}, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        run_op(1'b1, 1'b0, 5'd5,  17, 1'b0, 32'd21, 0);           // MUL 3x7
        run_op(1'b0, 1'b1, 5'd12, 9,  1'b1, 32'd0, 0);            // DIV 5/0
        run_op(1'b1, 1'b0, 5'd7,  0,  1'b0, 32'd0, 0);            // MUL timeout
        run_op(1'b0, 1'b1, 5'd13, 17, 1'b0, 32'd1, 5);            // flush in BUSY
        run_op(1'b1, 1'b0, 5'd3,  1,  1'b0, 32'hDEAD_BEEF, 0);    // ready at once
        run_op(1'b1, 1'b1, 5'd4,  3,  1'b1, 32'd0, 0);            // MUL wins
        run_op(1'b1, 1'b0, 5'd8,  4,  1'b0, 32'd1234, 0);         // back-to-back
        run_op(1'b1, 1'b0, 5'd9,  6,  1'b0, 32'd5678, 0);
        run_op(1'b0, 1'b1, 5'd10, 0,  1'b0, 32'd0, 0);            // DIV timeout
        run_op(1'b0, 1'b1, 5'd11, 40, 1'b0, 32'd77, 0);           // ready on last cycle
        run_op(1'b1, 1'b0, 5'd14, 2,  1'b0, 32'd99, 1);           // flush beats ready

        // Reset while out_valid is high clears outputs without a clock edge.
        dx_is_mul = 1'b1;
        dx_rd     = 5'd9;
        @(posedge clock); #1;
        @(posedge clock); #1;
        md_result_rdy = 1'b1;
        md_result     = 32'd55;
        @(posedge clock); #1;
        md_result_rdy = 1'b0;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_data", out_data, 32'd55);
        reset     = 1'b0;
        dx_is_mul = 1'b0;
        #1;
        chk("rst_done_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_done_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_done_data", out_data, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // Reset mid-BUSY returns to IDLE; a stray ready afterwards is ignored.
        dx_is_div = 1'b1;
        dx_rd     = 5'd11;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clock); #1;
        end
        reset     = 1'b0;
        dx_is_div = 1'b0;
        #1;
        chk("rst_busy_outs", {27'd0, ctrl_mult, ctrl_div, out_valid, out_rd[1:0]}, 32'd0);
        chk("rst_busy_stall", {31'd0, md_stall}, 32'd0);
        @(posedge clock); #1;
        reset         = 1'b1;
        md_result_rdy = 1'b1;
        md_result     = 32'd66;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
            chk("post_rst_stall", {31'd0, md_stall}, 32'd0);
        end
        md_result_rdy = 1'b0;

        // Issue after reset still works.
        run_op(1'b0, 1'b1, 5'd15, 2, 1'b0, 32'd3, 0);

        @(posedge clock); #5;
        chk("valid_count", n_valid, n_expected);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
